// File: rtl/neuro_bridge_pkg.sv
// Shared types and sizing helpers for the spike/rate-code bridge between
// char_pwm_gen and the neuron-side logic.
package neuro_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WINDOW_CYCLES_DEF = 8;
    localparam int WIN_IDX_W_DEF     = $clog2(WINDOW_CYCLES_DEF);

    // Window-index width for a given window length (length is always >= 2).
    function automatic int win_idx_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/digit_spike_window_counter_sat_counter.sv
// Saturating accumulator with synchronous clear. count_upd is the value
// including this cycle's increment, so a window can close on it directly.
module sat_counter
    import neuro_bridge_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count_upd
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_upd = count_q;
        if (inc && (count_q != MAX))
            count_upd = count_q + CNT_W'(1);
        count_d = clr ? '0 : count_upd;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/digit_spike_window_counter.sv
// Counts rising edges and high cycles of the digit spike stream over
// back-to-back windows and hands each result out on a valid/ready port.
module digit_spike_window_counter
    import neuro_bridge_pkg::*;
#(
    parameter int WINDOW_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             digit,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] high_count,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun
);

    localparam int              WIN_W    = win_idx_w(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             digit_q, digit_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic [CNT_W-1:0] high_count_q, high_count_d;
    logic             count_valid_q, count_valid_d;
    logic             overrun_q, overrun_d;

    logic             acc_clr, edge_inc, high_inc, close;
    logic [CNT_W-1:0] edge_upd, high_upd;

    sat_counter #(.CNT_W(CNT_W)) u_edge_acc (
        .clk(clk), .rst(rst), .clr(acc_clr), .inc(edge_inc), .count_upd(edge_upd)
    );

    sat_counter #(.CNT_W(CNT_W)) u_high_acc (
        .clk(clk), .rst(rst), .clr(acc_clr), .inc(high_inc), .count_upd(high_upd)
    );

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        digit_d       = digit_q;
        edge_count_d  = edge_count_q;
        high_count_d  = high_count_q;
        count_valid_d = count_valid_q;
        overrun_d     = overrun_q;
        acc_clr       = 1'b0;
        edge_inc      = 1'b0;
        high_inc      = 1'b0;
        close         = 1'b0;

        case (state_q)
            IDLE: begin
                acc_clr = 1'b1;
                win_d   = '0;
                digit_d = 1'b0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    // Abort wins even on the last window cycle; partial data is dropped.
                    state_d = IDLE;
                    acc_clr = 1'b1;
                    win_d   = '0;
                    digit_d = 1'b0;
                end else begin
                    edge_inc = digit & ~digit_q;
                    high_inc = digit;
                    digit_d  = digit;
                    if (win_q == WIN_LAST) begin
                        close   = 1'b1;
                        acc_clr = 1'b1;
                        win_d   = '0;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (close) begin
            if (!count_valid_q || count_ready) begin
                edge_count_d  = edge_upd;
                high_count_d  = high_upd;
                count_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (count_valid_q && count_ready) begin
            count_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            win_q         <= '0;
            digit_q       <= 1'b0;
            edge_count_q  <= '0;
            high_count_q  <= '0;
            count_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            digit_q       <= digit_d;
            edge_count_q  <= edge_count_d;
            high_count_q  <= high_count_d;
            count_valid_q <= count_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign edge_count  = edge_count_q;
    assign high_count  = high_count_q;
    assign count_valid = count_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_digit_spike_window_counter.sv
// Bench for digit_spike_window_counter: a cycle model pushes expected window
// results into a queue, a negedge monitor pops them on each handshake.
module tb_digit_spike_window_counter;

    localparam int WC   = 8;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, enable, digit, count_ready;
    logic [CW-1:0] edge_count, high_count;
    logic          count_valid, overrun;

    digit_spike_window_counter #(.WINDOW_CYCLES(WC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .digit(digit),
        .edge_count(edge_count), .high_count(high_count),
        .count_valid(count_valid), .count_ready(count_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int e; int h; } res_t;
    res_t exp_q[$];

    int errors = 0;
    int checks = 0;
    bit mon_on = 0;

    bit m_run, m_dq, m_valid, m_ovr;
    int m_w, m_ae, m_ah;

    // Drive one cycle of inputs, advance the reference model on the edge.
    task automatic cyc(input logic en, input logic d, input logic rdy);
        bit close;
        int ne, nh;
        enable = en; digit = d; count_ready = rdy;
        @(posedge clk);
        close = 0; ne = 0; nh = 0;
        if (rst) begin
            m_run = 0; m_dq = 0; m_w = 0; m_ae = 0; m_ah = 0;
            m_valid = 0; m_ovr = 0;
            exp_q.delete();
        end else begin
            if (!m_run) begin
                m_dq = 0; m_w = 0; m_ae = 0; m_ah = 0;
                if (en) m_run = 1;
            end else if (!en) begin
                m_run = 0; m_dq = 0; m_w = 0; m_ae = 0; m_ah = 0;
            end else begin
                if (d && !m_dq) m_ae = (m_ae >= SMAX) ? SMAX : m_ae + 1;
                if (d)          m_ah = (m_ah >= SMAX) ? SMAX : m_ah + 1;
                m_dq = d;
                if (m_w == WC - 1) begin
                    close = 1; ne = m_ae; nh = m_ah;
                    m_ae = 0; m_ah = 0; m_w = 0;
                end else begin
                    m_w++;
                end
            end
            if (close) begin
                if (!m_valid || rdy) begin
                    exp_q.push_back('{ne, nh});
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (count_valid !== m_valid) begin
                errors++;
                $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, count_valid, m_valid);
            end
            checks++;
            if (overrun !== m_ovr) begin
                errors++;
                $display("FAIL mon_overrun t=%0t got=%b exp=%b", $time, overrun, m_ovr);
            end
            if (count_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mon_result t=%0t got=%0d/%0d exp=<none queued>", $time, edge_count, high_count);
                end else begin
                    if (edge_count !== CW'(exp_q[0].e) || high_count !== CW'(exp_q[0].h)) begin
                        errors++;
                        $display("FAIL mon_result t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                                 edge_count, high_count, exp_q[0].e, exp_q[0].h);
                    end
                    if (count_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_window();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        mon_on = 1;
        rst = 1'b0;
        checks++;
        if (edge_count !== 4'd0 || high_count !== 4'd0 || count_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset got=%0d/%0d v=%b o=%b exp=0/0 v=0 o=0", edge_count, high_count, count_valid, overrun);
        end
    endtask

    // Enable-sampling edge is cycle 1; the w=7 sample lands on edge 9.
    task automatic test_zero_latency();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            if (i == 8) begin
                checks++;
                if (count_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early got=%b exp=0", count_valid);
                end
            end
        end
        checks++;
        if (count_valid !== 1'b1 || edge_count !== 4'd0 || high_count !== 4'd0) begin
            errors++;
            $display("FAIL latency_result got v=%b %0d/%0d exp v=1 0/0", count_valid, edge_count, high_count);
        end
        cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_pulse got=%b exp=0", count_valid);
        end
    endtask

    task automatic test_toggle();
        start_window();
        for (int i = 0; i < 2 * WC; i++) begin
            cyc(1'b1, logic'(i % 2 == 0), 1'b1);
            if (i == WC - 1 || i == 2 * WC - 1) begin
                checks++;
                if (count_valid !== 1'b1 || edge_count !== 4'd4 || high_count !== 4'd4) begin
                    errors++;
                    $display("FAIL toggle_w%0d got v=%b %0d/%0d exp v=1 4/4", i / WC, count_valid, edge_count, high_count);
                end
            end
        end
    endtask

    task automatic test_hold_high();
        start_window();
        for (int i = 0; i < 2 * WC; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (i == WC - 1) begin
                checks++;
                if (count_valid !== 1'b1 || edge_count !== 4'd1 || high_count !== 4'd8) begin
                    errors++;
                    $display("FAIL hold_w0 got v=%b %0d/%0d exp v=1 1/8", count_valid, edge_count, high_count);
                end
            end
            if (i == 2 * WC - 1) begin
                checks++;
                if (count_valid !== 1'b1 || edge_count !== 4'd0 || high_count !== 4'd8) begin
                    errors++;
                    $display("FAIL hold_w1 got v=%b %0d/%0d exp v=1 0/8", count_valid, edge_count, high_count);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        start_window();
        for (int i = 0; i < 2 * WC; i++) begin
            // Second window would be 1/8 if it wrongly overwrote the held 4/4.
            cyc(1'b1, (i < WC) ? logic'(i % 2 == 0) : 1'b1, 1'b0);
            if (i == WC - 1) begin
                checks++;
                if (count_valid !== 1'b1 || edge_count !== 4'd4 || high_count !== 4'd4 || overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_first got v=%b %0d/%0d o=%b exp v=1 4/4 o=0", count_valid, edge_count, high_count, overrun);
                end
            end
        end
        checks++;
        if (count_valid !== 1'b1 || edge_count !== 4'd4 || high_count !== 4'd4 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_held got v=%b %0d/%0d o=%b exp v=1 4/4 o=1", count_valid, edge_count, high_count, overrun);
        end
        cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got=%b exp=0", count_valid);
        end
        for (int i = 1; i < WC; i++) cyc(1'b1, logic'(i % 2 == 1), 1'b1);
        checks++;
        if (count_valid !== 1'b1 || edge_count !== 4'd4 || high_count !== 4'd4 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_next got v=%b %0d/%0d o=%b exp v=1 4/4 o=1", count_valid, edge_count, high_count, overrun);
        end
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        start_window();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (count_valid === 1'b1) seen++;
        end
        cyc(1'b0, 1'b1, 1'b1);
        if (count_valid === 1'b1) seen++;
        cyc(1'b1, 1'b1, 1'b1);
        if (count_valid === 1'b1) seen++;
        for (int i = 0; i < WC - 1; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (count_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_novalid got=%0d valid cycles exp=0", seen);
        end
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (count_valid !== 1'b1 || edge_count !== 4'd1 || high_count !== 4'd8) begin
            errors++;
            $display("FAIL abort_fresh got v=%b %0d/%0d exp v=1 1/8", count_valid, edge_count, high_count);
        end
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        start_window();
        for (int i = 0; i < WC; i++) cyc(1'b1, logic'(i % 2 == 0), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if (edge_count !== 4'd0 || high_count !== 4'd0 || count_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got %0d/%0d v=%b o=%b exp 0/0 v=0 o=0", edge_count, high_count, count_valid, overrun);
        end
        // Coming out of IDLE, the first window closes on the 9th enabled edge.
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            if (i == 8) begin
                checks++;
                if (count_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_idle_early got=%b exp=0", count_valid);
                end
            end
        end
        checks++;
        if (count_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle_close got=%b exp=1", count_valid);
        end
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; digit = 1'b0; count_ready = 1'b1;
        test_reset();
        test_zero_latency();
        test_toggle();
        test_hold_high();
        test_backpressure();
        test_abort();
        test_reset_mid();
        mon_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
